cw_encoder_top: RTL
===================

# cw_encoder_top

Constant-weight encoder for the 20-8 configuration. Consumes a serial binary message and emits a weight-8 codeword of length 2^20 as eight strictly increasing 20-bit error positions. Sits upstream of `decoder_top` and uses the same framing: `start` pulse, 20-bit word stream, one-cycle done pulse. Differential mapping: each 17-bit message field is a gap; each position is the previous position plus 1 plus the gap.

## Interface

Parameters:

- `CW_W`, 20, position width; codeword length is 2^CW_W.
- `CW_T`, 8, codeword weight, i.e. number of positions emitted.
- `DELTA_W`, 17, message bits per position. Constraint: CW_T·2^DELTA_W ≤ 2^CW_W. Message length is CW_T·DELTA_W = 136 bits.

Ports:

- `clk` in 1: single clock, rising edge.
- `rst_b` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that begins an encode; honoured only in IDLE.
- `bin_msg` in 1: serial message bit.
- `msg_wr` in 1: `bin_msg` is valid this cycle.
- `msg_rdy` out 1: block accepts bits; a bit transfers when `msg_wr & msg_rdy`.
- `cw_word` out CW_W: current position.
- `cw_valid` out 1: one-cycle strobe, `cw_word` is valid.
- `cw_done` out 1: one-cycle pulse, coincident with the last `cw_valid`.

## Operation

- Reset values: all outputs 0, state IDLE, counters 0, `prev_pos` 0.
- States:
  - IDLE: `msg_rdy`=0. `start` moves the block to SHIFT at the next edge and clears `bit_cnt`, `word_cnt` and `delta_sr`.
  - SHIFT: `msg_rdy`=1.
    - Each transfer shifts `bin_msg` into `delta_sr` (DELTA_W bits, MSB-first; the first bit received is the gap MSB) and increments `bit_cnt`.
    - On the transfer with `bit_cnt`=DELTA_W−1, the gap `d` is the 16 stored bits concatenated with the incoming bit.
    - At that same edge: `pos` = `d` if `word_cnt`=0, else `prev_pos`+1+`d`.
    - Also at that edge: `cw_word`←`pos`, `prev_pos`←`pos`, `cw_valid`←1, `bit_cnt`←0, `word_cnt`++.
  - If that word was number CW_T−1: `cw_done`←1, `msg_rdy`←0, state→IDLE. Otherwise stay in SHIFT.
- Arithmetic: CW_W-bit unsigned add with no overflow. The parameter constraint guarantees a maximum position of 2^CW_W−1. `d` is zero-extended to CW_W.
- `cw_word` holds its last value until the next `cw_valid`. It is not cleared by `start`.
- Boundaries:
  - `msg_wr` while `msg_rdy`=0 (IDLE): the bit is dropped.
  - `start` in SHIFT: ignored.
  - `start` in the same cycle as the final transfer: ignored; the block ends in IDLE.
  - `msg_wr` gaps: the block waits indefinitely and no partial state is lost.
  - `rst_b` low mid-encode: immediate return to reset values; the partial message is discarded.

## Timing

- One message bit per cycle maximum. Full throughput is CW_T·DELTA_W = 136 cycles from the first transfer to `cw_done`.
- `msg_rdy` rises 1 cycle after `start`.
- `cw_valid` rises in the cycle after the 17th, 34th, … 136th accepted bit. It is registered, so there is no combinational path from input to output.
- `cw_done` and the 8th `cw_valid` are in the same cycle. `msg_rdy` is low in that same cycle.
- At full throughput, consecutive `cw_valid` pulses are exactly DELTA_W cycles apart.
- `msg_rdy` depends only on state; there is no combinational dependency on `msg_wr`.

## Structure

- Package `cw_pkg` holds:
  - constants `CW_W`, `CW_T`, `DELTA_W`, `MSG_LEN`;
  - the state enum (IDLE, SHIFT);
  - a derived `WCNT_W`=clog2(CW_T) and `BCNT_W`=clog2(DELTA_W).
- The `decoder_top` side imports the same package.
- One sub-module is natural: `cw_delta_acc`. It owns `delta_sr`, `bit_cnt`, `prev_pos` and the adder, and reports `field_full` and `pos`. The FSM, word counter and output registers stay in `cw_encoder_top`.
- Include an elaboration-time check of the CW_T·2^DELTA_W ≤ 2^CW_W constraint.

## Test plan

1. **All zeros:** reset, `start`, then 136 zero bits back-to-back → `cw_word` = 0,1,2,3,4,5,6,7. `cw_valid` is spaced 17 cycles apart. `cw_done` coincides with word 7.
2. **All ones:** 136 one bits → 131071, 262143, 393215, 524287, 655359, 786431, 917503, 1048575. No wrap.
3. **Single set bit:** the 17th bit is 1, all others 0 → 1,2,3,4,5,6,7,8. Separately, only the 1st bit is 1 → 65536, 65537, …, 65543.
4. **Throttled writes:** `msg_wr` asserted every other cycle with all-zero data → same words as scenario 1, `cw_valid` spacing 34 cycles. Bits driven with `msg_rdy`=0 before `start` are ignored.
5. **Reset mid-encode:** pulse `rst_b` low after 3 words → all outputs 0 within the reset cycle. A fresh `start` with all zeros → 0..7.
6. **Late start pulses:** `start` re-pulsed during SHIFT, and in the cycle of the final transfer → no restart, output sequence unchanged, one `cw_done` per encode.

Source files
------------

// File: rtl/cw_pkg.sv
// cw_pkg: shared constants, state enum and counter widths for the 20-8 constant-weight encoder/decoder
package cw_pkg;
  localparam int CW_W    = 20;
  localparam int CW_T    = 8;
  localparam int DELTA_W = 17;
  localparam int MSG_LEN = CW_T * DELTA_W;
  localparam int WCNT_W  = $clog2(CW_T);
  localparam int BCNT_W  = $clog2(DELTA_W);
  typedef enum logic {IDLE, SHIFT} state_t;
endpackage

// File: rtl/cw_delta_acc.sv
// cw_delta_acc: gap shift register, bit counter and position adder (in: clk, rst_b, i_clr, i_shift, i_bit, i_first; out: o_field_full, o_pos)
module cw_delta_acc
  import cw_pkg::*;
(
  input  logic            clk,
  input  logic            rst_b,
  input  logic            i_clr,
  input  logic            i_shift,
  input  logic            i_bit,
  input  logic            i_first,
  output logic            o_field_full,
  output logic [CW_W-1:0] o_pos
);
  logic [BCNT_W-1:0]  r_bit_cnt;
  logic [DELTA_W-2:0] r_sr;
  logic [CW_W-1:0]    r_prev;
  logic [CW_W-1:0]    w_gap;
  assign w_gap        = CW_W'({r_sr, i_bit});
  assign o_field_full = r_bit_cnt == BCNT_W'(DELTA_W - 1);
  assign o_pos        = i_first ? w_gap : r_prev + CW_W'(1) + w_gap;
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_bit_cnt <= '0;
      r_sr      <= '0;
      r_prev    <= '0;
    end else if (i_clr) begin
      r_bit_cnt <= '0;
      r_sr      <= '0;
    end else if (i_shift) begin
      r_sr      <= {r_sr[DELTA_W-3:0], i_bit};
      r_bit_cnt <= o_field_full ? '0 : r_bit_cnt + BCNT_W'(1);
      r_prev    <= o_field_full ? o_pos : r_prev;
    end
  end
endmodule

// File: rtl/cw_encoder_top.sv
// cw_encoder_top: serial message to eight increasing 20-bit positions (in: clk, rst_b, start, bin_msg, msg_wr; out: msg_rdy, cw_word, cw_valid, cw_done)
module cw_encoder_top
  import cw_pkg::*;
(
  input  logic            clk,
  input  logic            rst_b,
  input  logic            start,
  input  logic            bin_msg,
  input  logic            msg_wr,
  output logic            msg_rdy,
  output logic [CW_W-1:0] cw_word,
  output logic            cw_valid,
  output logic            cw_done
);
  if ((64'(CW_T) << DELTA_W) > (64'(1) << CW_W)) begin : g_bad_params
    $error("cw_encoder_top: CW_T*2^DELTA_W exceeds 2^CW_W");
  end
  state_t            r_state, w_next;
  logic [WCNT_W-1:0] r_word_cnt;
  logic              w_xfer, w_clr, w_field_full, w_word_done, w_last;
  logic [CW_W-1:0]   w_pos;
  assign w_xfer      = msg_wr & msg_rdy;
  assign w_clr       = (r_state == IDLE) & start;
  assign w_word_done = w_xfer & w_field_full;
  assign w_last      = w_word_done & (r_word_cnt == WCNT_W'(CW_T - 1));
  cw_delta_acc u_acc (
    .clk         (clk),
    .rst_b       (rst_b),
    .i_clr       (w_clr),
    .i_shift     (w_xfer),
    .i_bit       (bin_msg),
    .i_first     (r_word_cnt == '0),
    .o_field_full(w_field_full),
    .o_pos       (w_pos)
  );
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) r_state <= IDLE;
    else        r_state <= w_next;
  end
  always_comb begin
    w_next = (r_state == IDLE) ? (start ? SHIFT : IDLE) : (w_last ? IDLE : SHIFT);
  end
  always_comb begin
    msg_rdy = r_state == SHIFT;
  end
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_word_cnt <= '0;
      cw_word    <= '0;
      cw_valid   <= 1'b0;
      cw_done    <= 1'b0;
    end else begin
      r_word_cnt <= w_clr ? '0 : w_word_done ? r_word_cnt + WCNT_W'(1) : r_word_cnt;
      cw_word    <= w_word_done ? w_pos : cw_word;
      cw_valid   <= w_word_done;
      cw_done    <= w_last;
    end
  end
endmodule
